// File: rtl/i2s_lock_sequencer.sv
// i2s_lock_sequencer: qualifies I2S LRCK framing and sequences enable/mute of the PCM1702 datapath
module i2s_lock_sequencer #(
  parameter int LOCK_FRAMES   = 16,
  parameter int UNMUTE_FRAMES = 256
) (
  input  logic       BCK,
  input  logic       RST,
  input  logic       LRCK,
  output logic       EN_OUT,
  output logic       MUTE,
  output logic       LED1,
  output logic       WORD64,
  output logic [6:0] FRAME_LEN
);
  localparam logic [7:0]  LP_LOCK   = 8'(LOCK_FRAMES);
  localparam logic [15:0] LP_UNMUTE = 16'(UNMUTE_FRAMES);
  typedef enum logic [1:0] {IDLE, ACQUIRE, SETTLE, RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic        r_lrck_q, r_lrck_q2, r_rise_seen, r_to_fired;
  logic [6:0]  r_bck_cnt, r_rise_pos, r_ref_len, w_ref_nxt;
  logic [7:0]  r_good_cnt, w_good_nxt, w_len;
  logic [15:0] r_frame_cnt, w_frame_nxt;
  logic        w_word64_nxt, w_fall, w_rise, w_valid, w_same, w_good, w_timeout;
  assign w_fall    = r_lrck_q2 & ~r_lrck_q;
  assign w_rise    = ~r_lrck_q2 & r_lrck_q;
  assign w_len     = {1'b0, r_bck_cnt} + 8'd1;
  assign w_valid   = ((w_len == 8'd48) || (w_len == 8'd64)) && r_rise_seen &&
                     (({1'b0, r_rise_pos} + 8'd1) == {1'b0, w_len[7:1]});
  assign w_same    = w_len == {1'b0, r_ref_len};
  assign w_good    = w_valid & w_same;
  assign w_timeout = (r_bck_cnt == 7'd127) & ~w_fall & ~r_to_fired;
  // Synchronise LRCK and measure frame length, rise position and a one-shot stall timeout
  always_ff @(posedge BCK) begin
    if (RST) begin
      r_lrck_q    <= 1'b0;
      r_lrck_q2   <= 1'b0;
      r_bck_cnt   <= 7'd0;
      r_rise_pos  <= 7'd0;
      r_rise_seen <= 1'b0;
      r_to_fired  <= 1'b0;
      FRAME_LEN   <= 7'd0;
    end else begin
      r_lrck_q    <= LRCK;
      r_lrck_q2   <= r_lrck_q;
      r_bck_cnt   <= w_fall ? 7'd0 : ((r_bck_cnt == 7'd127) ? 7'd127 : r_bck_cnt + 7'd1);
      r_rise_pos  <= w_rise ? r_bck_cnt : r_rise_pos;
      r_rise_seen <= w_fall ? 1'b0 : (r_rise_seen | w_rise);
      r_to_fired  <= w_fall ? 1'b0 : (r_to_fired | w_timeout);
      FRAME_LEN   <= w_fall ? (w_len[7] ? 7'd127 : w_len[6:0]) : FRAME_LEN;
    end
  end
  // State, lock counters and outputs registered from the next state
  always_ff @(posedge BCK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_good_cnt  <= 8'd0;
      r_frame_cnt <= 16'd0;
      r_ref_len   <= 7'd0;
      EN_OUT      <= 1'b0;
      MUTE        <= 1'b1;
      LED1        <= 1'b0;
      WORD64      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_ref_len   <= w_ref_nxt;
      EN_OUT      <= (w_state_nxt == SETTLE) || (w_state_nxt == RUN);
      MUTE        <= w_state_nxt != RUN;
      LED1        <= w_state_nxt == RUN;
      WORD64      <= w_word64_nxt;
    end
  end
  // Next-state: qualify frames, count lock/settle frames, fall back on faults
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_frame_nxt  = r_frame_cnt;
    w_ref_nxt    = r_ref_len;
    w_word64_nxt = WORD64;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (w_timeout) w_state_nxt = IDLE;
        else if (w_fall) begin
          w_ref_nxt  = w_len[6:0];
          w_good_nxt = (w_valid && ((r_good_cnt == 8'd0) || w_same)) ? r_good_cnt + 8'd1 : {7'd0, w_valid};
          if (w_good_nxt == LP_LOCK) begin
            w_state_nxt  = SETTLE;
            w_frame_nxt  = 16'd0;
            w_word64_nxt = w_ref_nxt == 7'd64;
          end
        end
      end
      SETTLE: begin
        if (w_timeout) w_state_nxt = IDLE;
        else if (w_fall) begin
          if (w_good) begin
            w_frame_nxt = r_frame_cnt + 16'd1;
            if (w_frame_nxt == LP_UNMUTE) w_state_nxt = RUN;
          end else begin
            w_state_nxt = ACQUIRE;
            w_good_nxt  = 8'd0;
          end
        end
      end
      RUN: begin
        if (w_timeout) w_state_nxt = IDLE;
        else if (w_fall && !w_good) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 8'd0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == IDLE) w_word64_nxt = 1'b0;
  end
endmodule

// File: tb/tb_i2s_lock_sequencer.sv
// tb_i2s_lock_sequencer: directed and randomized LRCK streams against a timestamp-based lock model
module tb_i2s_lock_sequencer;
  localparam int LOCK = 4;
  localparam int UNM  = 8;
  logic       BCK = 1'b0, RST = 1'b1, LRCK = 1'b1;
  logic       EN_OUT, MUTE, LED1, WORD64;
  logic [6:0] FRAME_LEN;
  int checks = 0, failures = 0;
  logic [2:0] s1, s2;
  i2s_lock_sequencer #(.LOCK_FRAMES(LOCK), .UNMUTE_FRAMES(UNM)) dut (
    .BCK(BCK), .RST(RST), .LRCK(LRCK), .EN_OUT(EN_OUT), .MUTE(MUTE),
    .LED1(LED1), .WORD64(WORD64), .FRAME_LEN(FRAME_LEN)
  );
  always #5 BCK = ~BCK;
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  // model: frame length and rise position come from edge timestamps of detected LRCK transitions
  int  e = 0, e0 = 0, er = 0, mode = 0, good = 0, frames = 0, ref_len = 0, flen = 0, len = 0;
  bit  rseen, lq, lq2, w64, mv, f, r, to, ok;
  always @(posedge BCK) begin
    e++;
    if (RST) begin
      mode = 0; e0 = e; rseen = 0; lq = 0; lq2 = 0; flen = 0; w64 = 0; good = 0; frames = 0; ref_len = 0; mv = 1;
    end else begin
      f   = lq2 && !lq;
      r   = !lq2 && lq;
      len = (e - e0 > 128) ? 128 : e - e0;
      to  = !f && (e - e0 == 128);
      ok  = (len == 48 || len == 64) && rseen && (er - e0 == len / 2);
      case (mode)
        0: if (f) begin mode = 1; good = 0; end
        1: if (to) mode = 0;
           else if (f) begin
             good = (ok && (good == 0 || len == ref_len)) ? good + 1 : int'(ok);
             ref_len = len;
             if (good == LOCK) begin mode = 2; frames = 0; w64 = (len == 64); end
           end
        2: if (to) mode = 0;
           else if (f) begin
             if (ok && len == ref_len) begin frames++; if (frames == UNM) mode = 3; end
             else begin mode = 1; good = 0; end
           end
        default: if (to) mode = 0;
           else if (f && !(ok && len == ref_len)) begin mode = 1; good = 0; end
      endcase
      if (mode == 0) w64 = 0;
      if (r) begin rseen = 1; er = e; end
      if (f) begin rseen = 0; e0 = e; flen = (len > 127) ? 127 : len; end
      lq2 = lq;
      lq  = LRCK;
    end
  end
  always @(negedge BCK) begin
    if (mv) begin
      chk("EN_OUT", 8'(EN_OUT), 8'(mode >= 2));
      chk("MUTE", 8'(MUTE), 8'(mode != 3));
      chk("LED1", 8'(LED1), 8'(mode == 3));
      chk("WORD64", 8'(WORD64), 8'(w64));
      chk("FRAME_LEN", 8'(FRAME_LEN), 8'(flen));
    end
  end
  task automatic frame(input int lo, input int hi);
    for (int i = 0; i < lo + hi; i++) begin
      @(posedge BCK); #1;
      if (i == 1) s1 = {EN_OUT, MUTE, LED1};
      if (i == 2) s2 = {EN_OUT, MUTE, LED1};
      LRCK = (i >= lo);
    end
  endtask
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin @(posedge BCK); #1; LRCK = v; end
  endtask
  task automatic do_reset(input int n, input bit lit);
    @(posedge BCK); #1; RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge BCK); #1;
      if (i == 0 && lit) begin
        chk("rst_en", 8'(EN_OUT), 8'd0);
        chk("rst_mute", 8'(MUTE), 8'd1);
        chk("rst_led", 8'(LED1), 8'd0);
        chk("rst_w64", 8'(WORD64), 8'd0);
        chk("rst_flen", 8'(FRAME_LEN), 8'd0);
      end
    end
    RST = 1'b0;
  endtask
  initial begin
    int sel, n, lo, hi;
    repeat (2) @(posedge BCK);
    do_reset(3, 1);
    hold(1'b1, 4);
    for (int k = 1; k <= 13; k++) begin
      frame(24, 24);
      if (k == 4) chk("l48_en_f4", 8'(s2[2]), 8'd0);
      if (k == 5) begin chk("l48_en_f5_pre", 8'(s1[2]), 8'd0); chk("l48_en_f5", 8'(s2[2]), 8'd1); end
      if (k == 12) chk("l48_mute_f12", 8'(s2[1]), 8'd1);
      if (k == 13) begin chk("l48_mute_f13_pre", 8'(s1[1]), 8'd1); chk("l48_mute_f13", 8'(s2[1]), 8'd0); chk("l48_led_f13", 8'(s2[0]), 8'd1); end
    end
    chk("l48_flen", 8'(FRAME_LEN), 8'd48);
    chk("l48_w64", 8'(WORD64), 8'd0);
    frame(20, 28);
    frame(24, 24);
    chk("asym_led_pre", 8'(s1[0]), 8'd1);
    chk("asym_led", 8'(s2[0]), 8'd0);
    chk("asym_mute", 8'(s2[1]), 8'd1);
    chk("asym_en", 8'(s2[2]), 8'd0);
    for (int k = 16; k <= 27; k++) begin
      frame(24, 24);
      if (k == 18) chk("asym_en_f18", 8'(s2[2]), 8'd0);
      if (k == 19) chk("asym_en_f19", 8'(s2[2]), 8'd1);
      if (k == 27) chk("asym_led_f27", 8'(s2[0]), 8'd1);
    end
    frame(32, 32);
    frame(32, 32);
    chk("chg_mute_pre", 8'(s1[1]), 8'd0);
    chk("chg_en_pre", 8'(s1[2]), 8'd1);
    chk("chg_mute", 8'(s2[1]), 8'd1);
    chk("chg_en", 8'(s2[2]), 8'd0);
    for (int k = 30; k <= 41; k++) begin
      frame(32, 32);
      if (k == 33) chk("chg_en_f33", 8'(s2[2]), 8'd1);
      if (k == 41) chk("chg_led_f41", 8'(s2[0]), 8'd1);
    end
    chk("l64_w64", 8'(WORD64), 8'd1);
    chk("l64_flen", 8'(FRAME_LEN), 8'd64);
    hold(1'b1, 40);
    chk("stall_led_early", 8'(LED1), 8'd1);
    hold(1'b1, 110);
    chk("stall_en", 8'(EN_OUT), 8'd0);
    chk("stall_mute", 8'(MUTE), 8'd1);
    chk("stall_led", 8'(LED1), 8'd0);
    chk("stall_w64", 8'(WORD64), 8'd0);
    chk("stall_flen", 8'(FRAME_LEN), 8'd64);
    for (int k = 1; k <= 13; k++) begin
      frame(32, 32);
      if (k == 1) chk("rearm_en_f1", 8'(s2[2]), 8'd0);
      if (k == 5) chk("rearm_en_f5", 8'(s2[2]), 8'd1);
      if (k == 13) chk("rearm_led_f13", 8'(s2[0]), 8'd1);
    end
    chk("rearm_w64", 8'(WORD64), 8'd1);
    do_reset(3, 1);
    hold(1'b1, 5);
    repeat (50) begin
      sel = $urandom_range(0, 99);
      n   = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          case ($urandom_range(0, 3))
            0: begin lo = $urandom_range(2, 46); frame(lo, 48 - lo); end
            1: frame($urandom_range(2, 70), $urandom_range(2, 70));
            2: hold(LRCK, $urandom_range(50, 200));
            default: do_reset($urandom_range(1, 3), 0);
          endcase
        end else if (sel < 45) frame(24, 24);
        else if (sel < 90) frame(32, 32);
        else begin
          hi = $urandom_range(2, 40);
          frame(($urandom_range(0, 1) == 1) ? 24 : 32, hi);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
